load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    WRITE,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: extracts and extends load lanes, and merges
// sub-word store data into the previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_lane = rd_word[{byte_off, 3'b000} +: 8];
    half_lane = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_W:    load_data = rd_word;
      F3_BU:   load_data = {24'h0, byte_lane};
      F3_HU:   load_data = {16'h0, half_lane};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = old_word;
    case (funct3)
      F3_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (byte_off[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: store_word = old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with read-modify-write for byte/half
// stores against a word-wide, combinationally read data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;

  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  // Rejection is decided from the live request so an error skips memory entirely.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = req_addr[0];
      F3_W:    req_err = |req_addr[1:0];
      F3_BU:   req_err = req_we;
      F3_HU:   req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS_U) req_err = 1'b1;
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .byte_off   (addr_q[1:0]),
    .rd_word    (mem_rd),
    .old_word   (old_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            f3_q      <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            if (req_err) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_funct3 == F3_W) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        LOAD: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_data;
        end
        READ: begin
          old_q <= mem_rd;
          state <= WRITE;
        end
        WRITE: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Qualifying with rst lets a reset landing on WRITE suppress the store.
  assign mem_we   = (state == WRITE) && !rst;
  assign mem_addr = (state == LOAD || state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wd   = (state == WRITE) ? store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:1023];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          we_count = 0;
  int          acc_count = 0;
  int          resp_count = 0;
  logic [31:0] last_wd = '0;
  logic [31:0] last_waddr = '0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = (mem_addr[31:2] < 30'd1024) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      we_count++;
      last_wd = mem_wd;
      last_waddr = mem_addr;
      mem[mem_addr[11:2]] <= mem_wd;
    end
    if (req_valid && req_ready && !rst) acc_count++;
    if (resp_valid) resp_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for the response, and check it and its hold.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid = 1'b0;
    check({tag, " mem_addr"}, mem_addr, (exp_lat > 1) ? {addr[31:2], 2'b00} : 32'h0);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " err"}, 32'(resp_err), 32'(exp_err));
    tick();
    check({tag, " valid pulse"}, 32'(resp_valid), 32'd0);
    check({tag, " rdata hold"}, resp_rdata, exp_rdata);
  endtask

  initial begin
    int wb;
    int ab;
    int rb;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    tick();
    tick();
    rst = 1'b0;
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset valid", 32'(resp_valid), 32'd0);
    check("reset rdata", resp_rdata, 32'h0);
    check("reset err", 32'(resp_err), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);

    // Word store
    wb = we_count;
    run_req("sw", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    check("sw we count", 32'(we_count - wb), 32'd1);
    check("sw wd", last_wd, 32'hDEADBEEF);
    check("sw waddr", last_waddr, 32'h10);
    check("sw mem", mem[4], 32'hDEADBEEF);

    // Byte and half stores via read-modify-write
    mem[4] = 32'h11223344;
    wb = we_count;
    run_req("sb", 1'b1, F3_B, 32'h12, 32'h000000AB, 3, 32'h0, 1'b0);
    check("sb we count", 32'(we_count - wb), 32'd1);
    check("sb wd", last_wd, 32'h11AB3344);
    check("sb mem", mem[4], 32'h11AB3344);
    run_req("sh", 1'b1, F3_H, 32'h16, 32'h1234CAFE, 3, 32'h0, 1'b0);
    check("sh wd", last_wd, 32'hCAFE0000);

    // Loads with sign/zero extension
    mem[4] = 32'h8000F0FF;
    run_req("lb", 1'b0, F3_B, 32'h10, 32'h0, 2, 32'hFFFFFFFF, 1'b0);
    run_req("lbu", 1'b0, F3_BU, 32'h10, 32'h0, 2, 32'h000000FF, 1'b0);
    run_req("lh", 1'b0, F3_H, 32'h12, 32'h0, 2, 32'hFFFF8000, 1'b0);
    run_req("lhu", 1'b0, F3_HU, 32'h12, 32'h0, 2, 32'h00008000, 1'b0);
    run_req("lb1", 1'b0, F3_B, 32'h11, 32'h0, 2, 32'hFFFFFFF0, 1'b0);
    run_req("lw", 1'b0, F3_W, 32'h10, 32'h0, 2, 32'h8000F0FF, 1'b0);

    // Rejected accesses
    wb = we_count;
    run_req("lw mis", 1'b0, F3_W, 32'h11, 32'h0, 1, 32'h0, 1'b1);
    run_req("sh mis", 1'b1, F3_H, 32'h13, 32'h5555, 1, 32'h0, 1'b1);
    run_req("f3 011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1);
    run_req("sw range", 1'b1, F3_W, 32'h1000, 32'h12345678, 1, 32'h0, 1'b1);
    run_req("sbu", 1'b1, F3_BU, 32'h10, 32'h77, 1, 32'h0, 1'b1);
    check("err no write", 32'(we_count - wb), 32'd0);
    check("err mem intact", mem[4], 32'h8000F0FF);

    // Reset landing on the WRITE cycle of a byte store
    mem[5] = 32'hCAFEBABE;
    wb = we_count;
    rb = resp_count;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h14;
    req_wdata  = 32'h55;
    tick();
    req_valid = 1'b0;
    tick();
    check("rst in write mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst gates mem_we", 32'(mem_we), 32'd0);
    tick();
    rst = 1'b0;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    tick();
    check("rst no write", 32'(we_count - wb), 32'd0);
    check("rst mem intact", mem[5], 32'hCAFEBABE);
    check("rst no resp", 32'(resp_count - rb), 32'd0);

    // req_valid held high: one store per three cycles
    wb = we_count;
    ab = acc_count;
    rb = resp_count;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h20;
    req_wdata  = 32'h0BADF00D;
    repeat (9) tick();
    req_valid = 1'b0;
    check("b2b accepts", 32'(acc_count - ab), 32'd3);
    check("b2b writes", 32'(we_count - wb), 32'd3);
    check("b2b resps", 32'(resp_count - rb), 32'd3);
    check("b2b ready", 32'(req_ready), 32'd1);
    check("b2b mem", mem[8], 32'h0BADF00D);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
